// File: rtl/impl_mon_pkg.sv
// Shared types for the implication/equivalence monitor.
package impl_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  typedef enum {
    RES_NONE,
    RES_PASS,
    RES_FAIL,
    RES_VAC
  } result_e;

  localparam int unsigned MAX_DELAY = 15;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/implication_monitor.sv
// Hardware checker for "ante |-> ##DELAY cons" with pulses, counters and sticky error.
// Define IMPL_MON_IFF_EN for equivalence mode "ante iff ##DELAY cons" (vacuous outputs tied 0).
module implication_monitor
  import impl_mon_pkg::*;
#(
  parameter int unsigned DELAY = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             ante,
  input  logic             cons,
  input  logic             clear,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic             vac_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic             err_sticky,
  output logic [1:0]       state
);

  if (DELAY > MAX_DELAY) begin : g_bad_delay
    $fatal(1, "implication_monitor: DELAY exceeds MAX_DELAY");
  end

  logic    new_vld, new_ante, vac_d;
  logic    mat_vld, mat_ante;
  result_e res;
  logic    pass_d, fail_d, err_d;
  logic    pass_q, fail_q, vac_q, err_q;
  state_e  state_q, state_d;

  // Each obligation carries the ante value it must be matched against;
  // in implication mode that is always 1, so the same compare serves both modes.
`ifdef IMPL_MON_IFF_EN
  assign new_vld  = enable;
  assign new_ante = ante;
  assign vac_d    = 1'b0;
`else
  assign new_vld  = enable & ante;
  assign new_ante = 1'b1;
  assign vac_d    = enable & ~ante;
`endif

  if (DELAY == 0) begin : g_nopipe
    assign mat_vld  = new_vld;
    assign mat_ante = new_ante;
  end else begin : g_pipe
    logic [DELAY-1:0] vld_q, ante_q;

    // Only reset flushes pending obligations; clear deliberately leaves them in flight.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= '0;
        ante_q <= '0;
      end else begin
        vld_q[0]  <= new_vld;
        ante_q[0] <= new_ante;
        for (int unsigned i = 1; i < DELAY; i++) begin
          vld_q[i]  <= vld_q[i-1];
          ante_q[i] <= ante_q[i-1];
        end
      end
    end

    assign mat_vld  = vld_q[DELAY-1];
    assign mat_ante = ante_q[DELAY-1];
  end

  always_comb begin
    res = RES_NONE;
    if (mat_vld) begin
      res = (cons == mat_ante) ? RES_PASS : RES_FAIL;
    end
  end

  assign pass_d = (res == RES_PASS);
  assign fail_d = (res == RES_FAIL);
  assign err_d  = clear ? 1'b0 : (err_q | fail_d);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fail_d) state_d = FAULT;
                 else if (enable) state_d = RUN;
        RUN:     if (fail_d) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      vac_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      vac_q   <= vac_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // Counters advance on the same edge as the pulse register, so clear masks that result.
  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(pass_d), .clr_i(clear), .cnt_o(pass_cnt)
  );
  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(fail_d), .clr_i(clear), .cnt_o(fail_cnt)
  );
  sat_counter #(.W(CNT_W)) u_vac_cnt (
    .clk_i (clk), .rst_ni(rst_n), .inc_i(vac_d), .clr_i(clear), .cnt_o(vac_cnt)
  );

  assign pass_pulse = pass_q;
  assign fail_pulse = fail_q;
  assign vac_pulse  = vac_q;
  assign err_sticky = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_implication_monitor.sv
// Directed bench for implication_monitor at DELAY=0, DELAY=2 (CNT_W=4) and DELAY=3.
module tb_implication_monitor;
  import impl_mon_pkg::*;

  logic clk, rst_n, enable, ante, cons, clear;

  logic        p0, f0, v0, e0;
  logic [15:0] pc0, fc0, vc0;
  logic [1:0]  s0;
  logic        p2, f2, v2, e2;
  logic [3:0]  pc2, fc2, vc2;
  logic [1:0]  s2;
  logic        p3, f3, v3, e3;
  logic [15:0] pc3, fc3, vc3;
  logic [1:0]  s3;

  int n_checks = 0;
  int n_errors = 0;

  implication_monitor #(.DELAY(0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ante(ante), .cons(cons), .clear(clear),
    .pass_pulse(p0), .fail_pulse(f0), .vac_pulse(v0), .pass_cnt(pc0), .fail_cnt(fc0),
    .vac_cnt(vc0), .err_sticky(e0), .state(s0)
  );
  implication_monitor #(.DELAY(2), .CNT_W(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ante(ante), .cons(cons), .clear(clear),
    .pass_pulse(p2), .fail_pulse(f2), .vac_pulse(v2), .pass_cnt(pc2), .fail_cnt(fc2),
    .vac_cnt(vc2), .err_sticky(e2), .state(s2)
  );
  implication_monitor #(.DELAY(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ante(ante), .cons(cons), .clear(clear),
    .pass_pulse(p3), .fail_pulse(f3), .vac_pulse(v3), .pass_cnt(pc3), .fail_cnt(fc3),
    .vac_cnt(vc3), .err_sticky(e3), .state(s3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic a, input logic c);
    enable = en;
    ante   = a;
    cons   = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Test 1 vectors; expected pulses packed {pass,fail,vac}.
  logic       t1_a [4];
  logic       t1_c [4];
  logic [2:0] t1_exp [4];
  int         t1_pc, t1_fc, t1_vc;

  // Test 3 vectors: {enable, ante, cons, pass, fail, vac}.
  logic [5:0] t3 [5];

  initial begin
    t1_a = '{1'b0, 1'b0, 1'b1, 1'b1};
    t1_c = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef IMPL_MON_IFF_EN
    t1_exp = '{3'b100, 3'b010, 3'b100, 3'b010};
    t1_pc = 2; t1_fc = 2; t1_vc = 0;
`else
    t1_exp = '{3'b001, 3'b001, 3'b100, 3'b010};
    t1_pc = 1; t1_fc = 1; t1_vc = 2;
`endif
    t3 = '{6'b110_000, 6'b110_000, 6'b111_100, 6'b000_010, 6'b001_100};

    // Test 1: DELAY=0 basic outcomes
    do_reset();
    check("rst pulses", {p0, f0, v0}, 3'b000);
    check("rst pass_cnt", pc0, 0);
    check("rst fail_cnt", fc0, 0);
    check("rst vac_cnt", vc0, 0);
    check("rst err", e0, 0);
    check("rst state", s0, IDLE);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1_a[i], t1_c[i]);
      tick();
      check($sformatf("t1 pulses %0d", i), {p0, f0, v0}, t1_exp[i]);
    end
    drive(1'b0, 1'b0, 1'b0);
    check("t1 pass_cnt", pc0, t1_pc);
    check("t1 fail_cnt", fc0, t1_fc);
    check("t1 vac_cnt", vc0, t1_vc);
    check("t1 err", e0, 1);
    check("t1 state", s0, FAULT);
    tick();
    check("t1 idle pulses", {p0, f0, v0}, 3'b000);
    check("t1 fault hold", s0, FAULT);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t1 clr pass_cnt", pc0, 0);
    check("t1 clr err", e0, 0);
    check("t1 clr state", s0, IDLE);

    // Test 2: DELAY=2 single obligation, pass then fail
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("t2 c5 pulses", {p2, f2, v2}, 3'b000);
    check("t2 state run", s2, RUN);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("t2 c6 pulses", {p2, f2, v2}, 3'b000);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check("t2 c8 pass", {p2, f2, v2}, 3'b100);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("t2 c9 quiet", {p2, f2, v2}, 3'b000);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("t2 fail", {p2, f2, v2}, 3'b010);
    check("t2 err", e2, 1);
    check("t2 state fault", s2, FAULT);

    // Test 3: DELAY=2 overlapping obligations
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(t3[i][5], t3[i][4], t3[i][3]);
      tick();
      check($sformatf("t3 pulses %0d", i), {p2, f2, v2}, t3[i][2:0]);
    end
    check("t3 pass_cnt", pc2, 2);
    check("t3 fail_cnt", fc2, 1);
    check("t3 vac_cnt", vc2, 0);

    // Test 4: CNT_W=4 saturation over 20 passing obligations
    do_reset();
    for (int i = 0; i < 22; i++) begin
      int m;
      drive(i < 20, i < 20, 1'b1);
      tick();
      m = (i >= 1) ? i - 1 : 0;
      check($sformatf("t4 pass_cnt %0d", i), pc2, (m > 15) ? 15 : m);
    end
    check("t4 fail_cnt", fc2, 0);

    // Test 5: DELAY=3 clear masks counting, reset flushes pending
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("t5 state run", s3, RUN);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("t5 c8 pulses", {p3, f3, v3}, 3'b000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t5 fail pulse", {p3, f3, v3}, 3'b010);
    check("t5 fail_cnt", fc3, 0);
    check("t5 err", e3, 0);
    check("t5 state idle", s3, IDLE);
    check("t5 pass_cnt", pc3, 0);
    check("t5 vac_cnt", vc3, 0);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5 flushed %0d", i), {p3, f3}, 2'b00);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
